nibble_serial_adder: RTL

//   Multi-cycle WIDTH-bit adder that processes one 4-bit nibble per clock, LSB nibble first.

---
 rtl/nibble_serial_adder_pkg.sv | 10 +
 rtl/nibble_serial_adder_cl_four_bit_adder.sv | 23 ++
 rtl/nibble_serial_adder.sv | 77 +++++++
 3 files changed

// File: rtl/nibble_serial_adder_pkg.sv
// nibble_serial_adder_pkg: shared FSM encoding, nibble width and counter-width helper
package nibble_serial_adder_pkg;
   localparam logic [1:0] ST_IDLE = 2'd0;
   localparam logic [1:0] ST_RUN  = 2'd1;
   localparam logic [1:0] ST_DONE = 2'd2;
   localparam int NIB_W = 4;
   function automatic int cnt_w(input int nib);
      return (nib > 1) ? $clog2(nib) : 1;
   endfunction
endpackage

// File: rtl/nibble_serial_adder_cl_four_bit_adder.sv
// cl_four_bit_adder: 4-bit carry-lookahead adder
// ports: a, b (4-bit addends), cin -> s (4-bit sum), cout (carry out of bit 3)
module cl_four_bit_adder (
   input  logic [3:0] a,
   input  logic [3:0] b,
   input  logic       cin,
   output logic [3:0] s,
   output logic       cout
);
   logic [3:0] g, p;
   logic [4:0] c;
   always_comb begin
      g = a & b;
      p = a ^ b;
      c[0] = cin;
      c[1] = g[0] | (p[0] & cin);
      c[2] = g[1] | (p[1] & g[0]) | (p[1] & p[0] & cin);
      c[3] = g[2] | (p[2] & g[1]) | (p[2] & p[1] & g[0]) | (p[2] & p[1] & p[0] & cin);
      c[4] = g[3] | (p[3] & g[2]) | (p[3] & p[2] & g[1]) | (p[3] & p[2] & p[1] & g[0]) | (&p & cin);
      s    = p ^ c[3:0];
      cout = c[4];
   end
endmodule

// File: rtl/nibble_serial_adder.sv
// nibble_serial_adder: WIDTH-bit adder processing one nibble per clock, LSB nibble first
// ports: clk, rst (sync, active-high); in_valid/in_ready with a, b, cin;
//        out_valid/out_ready with sum, cout, overflow (held until the next result)
module nibble_serial_adder
   import nibble_serial_adder_pkg::*;
#(
   parameter int WIDTH = 16
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   input  logic             cin,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [WIDTH-1:0] sum,
   output logic             cout,
   output logic             overflow
);
   localparam int NIB = WIDTH / NIB_W;
   localparam int CW  = cnt_w(NIB);
   logic [1:0]       state;
   logic [WIDTH-1:0] a_sh, b_sh;
   logic             carry, a_msb, b_msb, co;
   logic [CW-1:0]    cnt;
   logic [NIB_W-1:0] s;
   cl_four_bit_adder u_add (
      .a    (a_sh[NIB_W-1:0]),
      .b    (b_sh[NIB_W-1:0]),
      .cin  (carry),
      .s    (s),
      .cout (co)
   );
   assign in_ready  = state == ST_IDLE;
   assign out_valid = state == ST_DONE;
   always_ff @(posedge clk) begin
      if (rst) begin
         state    <= ST_IDLE;
         a_sh     <= '0;
         b_sh     <= '0;
         carry    <= 1'b0;
         a_msb    <= 1'b0;
         b_msb    <= 1'b0;
         cnt      <= '0;
         sum      <= '0;
         cout     <= 1'b0;
         overflow <= 1'b0;
      end else if (state == ST_IDLE) begin
         if (in_valid) begin
            a_sh  <= a;
            b_sh  <= b;
            carry <= cin;
            a_msb <= a[WIDTH-1];
            b_msb <= b[WIDTH-1];
            cnt   <= '0;
            state <= ST_RUN;
         end
      end else if (state == ST_RUN) begin
         // each nibble enters at the top so the first one ends up at bit 0
         sum   <= {s, sum[WIDTH-1:NIB_W]};
         carry <= co;
         a_sh  <= a_sh >> NIB_W;
         b_sh  <= b_sh >> NIB_W;
         cnt   <= cnt + 1'b1;
         if (cnt == CW'(NIB - 1)) begin
            state    <= ST_DONE;
            cout     <= co;
            overflow <= (a_msb == b_msb) && (s[NIB_W-1] != a_msb);
         end
      end else begin
         // the unused encoding falls back to IDLE
         state <= (state == ST_DONE && !out_ready) ? ST_DONE : ST_IDLE;
      end
   end
endmodule
